// File: rtl/freqdiv_period_meter.sv
// Period and high-time meter for a clock-like signal asynchronous to wb_clk_i.
// Reports each rise-to-rise measurement with a valid pulse and tracks lock on repeated periods.
module freqdiv_period_meter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_COUNT  = 4
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             en,
   input  logic             sig_i,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             valid_o,
   output logic             locked_o,
   output logic             timeout_o
);

   localparam int MATCH_W = $clog2(LOCK_COUNT);
   localparam logic [MATCH_W-1:0] MATCH_MAX  = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
   localparam logic [MATCH_W-1:0] MATCH_ZERO = {MATCH_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2
   } state_t;

   state_t                 state_r, state_next_s;
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   s_d_r;
   logic                   s_s;
   logic                   rise_s;
   logic [CNT_W-1:0]       cnt_r, cnt_next_s;
   logic [CNT_W-1:0]       hcnt_r, hcnt_next_s;
   logic [MATCH_W-1:0]     match_r, match_next_s;
   logic                   first_r, first_next_s;
   logic [CNT_W-1:0]       period_r, period_next_s;
   logic [CNT_W-1:0]       high_r, high_next_s;
   logic                   valid_r, valid_next_s;
   logic                   locked_r, locked_next_s;
   logic                   timeout_r, timeout_next_s;

   assign s_s    = sync_r[SYNC_STAGES-1];
   assign rise_s = s_s & ~s_d_r;

   // Synchronizer chain plus the one-cycle delay used for edge detection.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync_r <= {SYNC_STAGES{1'b0}};
         s_d_r  <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], sig_i};
         s_d_r  <= s_s;
      end
   end

   // FSM state register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state, counter and result logic; en low dominates every event.
   always_comb begin
      state_next_s   = state_r;
      cnt_next_s     = cnt_r;
      hcnt_next_s    = hcnt_r;
      match_next_s   = match_r;
      first_next_s   = first_r;
      period_next_s  = period_r;
      high_next_s    = high_r;
      valid_next_s   = 1'b0;
      locked_next_s  = locked_r;
      timeout_next_s = timeout_r;
      if (!en) begin
         state_next_s  = ST_IDLE;
         cnt_next_s    = CNT_ZERO;
         hcnt_next_s   = CNT_ZERO;
         match_next_s  = MATCH_ZERO;
         first_next_s  = 1'b1;
         locked_next_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_next_s = ST_ARM;
               first_next_s = 1'b1;
            end
            ST_ARM: begin
               first_next_s = 1'b1;
               if (rise_s) begin
                  cnt_next_s   = CNT_ONE;
                  hcnt_next_s  = CNT_ONE;
                  state_next_s = ST_MEASURE;
               end else begin
                  state_next_s = ST_ARM;
               end
            end
            ST_MEASURE: begin
               // A rise on the saturating cycle still counts as a measurement.
               if (rise_s) begin
                  period_next_s  = cnt_r;
                  high_next_s    = hcnt_r;
                  valid_next_s   = 1'b1;
                  timeout_next_s = 1'b0;
                  cnt_next_s     = CNT_ONE;
                  hcnt_next_s    = CNT_ONE;
                  first_next_s   = 1'b0;
                  if (first_r) begin
                     match_next_s = MATCH_ZERO;
                  end else if (cnt_r == period_r) begin
                     match_next_s = (match_r == MATCH_MAX) ? MATCH_MAX : match_r + MATCH_ONE;
                  end else begin
                     match_next_s = MATCH_ZERO;
                  end
                  locked_next_s = (match_next_s == MATCH_MAX);
               end else if (cnt_r == CNT_MAX) begin
                  timeout_next_s = 1'b1;
                  locked_next_s  = 1'b0;
                  match_next_s   = MATCH_ZERO;
                  first_next_s   = 1'b1;
                  state_next_s   = ST_ARM;
               end else begin
                  cnt_next_s = cnt_r + CNT_ONE;
                  if (s_s) begin
                     hcnt_next_s = hcnt_r + CNT_ONE;
                  end else begin
                     hcnt_next_s = hcnt_r;
                  end
               end
            end
            default: begin
               state_next_s = ST_IDLE;
            end
         endcase
      end
   end

   // Counters, lock tracking and registered outputs.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cnt_r     <= CNT_ZERO;
         hcnt_r    <= CNT_ZERO;
         match_r   <= MATCH_ZERO;
         first_r   <= 1'b1;
         period_r  <= CNT_ZERO;
         high_r    <= CNT_ZERO;
         valid_r   <= 1'b0;
         locked_r  <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         cnt_r     <= cnt_next_s;
         hcnt_r    <= hcnt_next_s;
         match_r   <= match_next_s;
         first_r   <= first_next_s;
         period_r  <= period_next_s;
         high_r    <= high_next_s;
         valid_r   <= valid_next_s;
         locked_r  <= locked_next_s;
         timeout_r <= timeout_next_s;
      end
   end

   assign period_o  = period_r;
   assign high_o    = high_r;
   assign valid_o   = valid_r;
   assign locked_o  = locked_r;
   assign timeout_o = timeout_r;

endmodule

// File: tb/tb_freqdiv_period_meter.sv
// Self-checking bench for freqdiv_period_meter: directed scenarios plus randomized pulse trains,
// compared every cycle against a timestamp-based reference model.
module tb_freqdiv_period_meter;

   localparam int CNT_W = 8;
   localparam int SYNC  = 2;
   localparam int LOCK  = 4;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             sig;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high;
   logic             valid;
   logic             locked;
   logic             timeout;

   int tests = 0;
   int fails = 0;

   freqdiv_period_meter #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC),
      .LOCK_COUNT (LOCK)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .en       (en),
      .sig_i    (sig),
      .period_o (period),
      .high_o   (high),
      .valid_o  (valid),
      .locked_o (locked),
      .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   // Reference model: rise timestamps, high samples per window, run length of equal periods.
   bit dly[$];
   bit s_at[int];
   int cyc = 0;
   int mode = 0;          // 0 idle, 1 waiting for arming rise, 2 measuring
   int last_rise = 0;
   int prev_per = 0;
   int run = 0;
   bit first_v = 1'b1;
   int exp_period = 0;
   int exp_high = 0;
   bit exp_valid = 1'b0;
   bit exp_locked = 1'b0;
   bit exp_timeout = 1'b0;
   bit started = 1'b0;

   initial begin : model
      bit s, sd, rise;
      int per, hi;
      for (int k = 0; k <= SYNC; k++) dly.push_back(1'b0);
      forever begin
         @(posedge clk);
         started = 1'b1;
         cyc++;
         s    = dly[SYNC-1];
         sd   = dly[SYNC];
         rise = s && !sd;
         if (rst) begin
            exp_period = 0; exp_high = 0; exp_valid = 1'b0; exp_locked = 1'b0; exp_timeout = 1'b0;
            mode = 0; run = 0;
            dly.delete();
            for (int k = 0; k <= SYNC; k++) dly.push_back(1'b0);
         end else begin
            exp_valid = 1'b0;
            s_at[cyc] = s;
            if (!en) begin
               mode = 0; exp_locked = 1'b0; run = 0;
            end else if (mode == 0) begin
               mode = 1;
            end else if (mode == 1) begin
               if (rise) begin
                  mode = 2; last_rise = cyc; first_v = 1'b1;
               end
            end else if (rise) begin
               per = cyc - last_rise;
               hi = 0;
               for (int k = last_rise; k < cyc; k++) hi += int'(s_at[k]);
               exp_period = per; exp_high = hi; exp_valid = 1'b1; exp_timeout = 1'b0;
               if (first_v) run = 1;
               else if (per == prev_per) run++;
               else run = 1;
               exp_locked = (run >= LOCK);
               prev_per = per; first_v = 1'b0; last_rise = cyc;
            end else if (cyc - last_rise == MAXC) begin
               exp_timeout = 1'b1; exp_locked = 1'b0; run = 0; mode = 1;
            end
            dly.push_front(sig);
            void'(dly.pop_back());
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (started) begin
         tests++;
         if (period !== CNT_W'(exp_period) || high !== CNT_W'(exp_high) || valid !== exp_valid ||
             locked !== exp_locked || timeout !== exp_timeout) begin
            fails++;
            $display("FAIL cycle_cmp t=%0t got p=%0d h=%0d v=%b l=%b t=%b, expected p=%0d h=%0d v=%b l=%b t=%b",
                     $time, period, high, valid, locked, timeout,
                     exp_period, exp_high, exp_valid, exp_locked, exp_timeout);
         end
      end
   end

   typedef struct {
      int per;
      int hi;
      bit lk;
   } vrec_t;
   vrec_t vlog[$];

   initial begin : valid_monitor
      forever begin
         @(posedge clk);
         #1;
         if (valid === 1'b1) vlog.push_back('{int'(period), int'(high), locked});
      end
   end

   task automatic square(input int h, input int l, input int np);
      for (int p = 0; p < np; p++) begin
         for (int i = 0; i < h + l; i++) begin
            sig = (i < h);
            @(negedge clk);
         end
      end
   endtask

   task automatic drive(input bit v, input int n);
      sig = v;
      repeat (n) @(negedge clk);
   endtask

   initial begin : stimulus
      int base, i10, first_valid, h, r;
      int ns[4] = '{3, 4, 6, 11};
      rst = 1'b1; en = 1'b0; sig = 1'b0;

      // Reset with the input toggling.
      repeat (3) begin
         @(negedge clk);
         sig = ~sig;
      end
      chk("rst_period", int'(period), 0);
      chk("rst_high", int'(high), 0);
      chk("rst_flags", int'({valid, locked, timeout}), 0);
      chk("rst_no_valid", vlog.size(), 0);
      rst = 1'b0;

      // 4/4 square wave.
      base = vlog.size();
      sig = 1'b0; en = 1'b1;
      square(4, 4, 8);
      chk("sq8_count", int'(vlog.size() >= base + 5), 1);
      if (vlog.size() >= base + 5) begin
         for (int k = 0; k < 5; k++) begin
            chk("sq8_period", vlog[base+k].per, 8);
            chk("sq8_high", vlog[base+k].hi, 4);
            chk("sq8_lock", int'(vlog[base+k].lk), int'(k >= 3));
         end
      end

      // Period 3, then period 10 relock.
      square(2, 1, 10);
      chk("p3_period", vlog[vlog.size()-1].per, 3);
      chk("p3_high", vlog[vlog.size()-1].hi, 2);
      chk("p3_lock", int'(locked), 1);
      base = vlog.size();
      square(5, 5, 8);
      i10 = -1;
      for (int k = base; k < vlog.size(); k++) if (i10 < 0 && vlog[k].per == 10) i10 = k;
      chk("p10_found", int'(i10 >= 0 && i10 + 3 < vlog.size()), 1);
      if (i10 >= 0 && i10 + 3 < vlog.size()) begin
         chk("p10_first_unlocked", int'(vlog[i10].lk), 0);
         chk("p10_third_unlocked", int'(vlog[i10+2].lk), 0);
         chk("p10_fourth_locked", int'(vlog[i10+3].lk), 1);
         chk("p10_high", vlog[i10+3].hi, 5);
      end

      // Single rise then a held-low input saturates the counter.
      base = vlog.size();
      drive(1'b1, 2);
      drive(1'b0, 300);
      chk("to_valids", vlog.size() - base, 1);
      chk("to_flag", int'(timeout), 1);
      chk("to_period_held", int'(period), 10);
      chk("to_high_held", int'(high), 5);
      chk("to_unlocked", int'(locked), 0);
      square(4, 4, 5);
      chk("to_cleared", int'(timeout), 0);
      chk("to_resume_period", vlog[vlog.size()-1].per, 8);

      // en dropped midway through a period.
      square(4, 4, 2);
      chk("en_locked_before", int'(locked), 1);
      drive(1'b1, 2);
      en = 1'b0;
      drive(1'b1, 1);
      chk("en_valid_low", int'(valid), 0);
      chk("en_locked_low", int'(locked), 0);
      chk("en_period_held", int'(period), 8);
      drive(1'b1, 1);
      drive(1'b0, 4);
      drive(1'b1, 2);
      en = 1'b1;
      first_valid = -1;
      for (int i = 0; i < 30; i++) begin
         sig = (((i + 2) % 8) < 4);
         @(negedge clk);
         if (valid === 1'b1 && first_valid < 0) first_valid = i;
      end
      chk("en_two_rises", int'(first_valid > 8 && first_valid <= 24), 1);

      // Divided-clock inputs.
      foreach (ns[j]) begin
         h = ns[j] / 2;
         square(h, ns[j] - h, LOCK + 4);
         chk("div_period", vlog[vlog.size()-1].per, ns[j]);
         chk("div_high", vlog[vlog.size()-1].hi, h);
         chk("div_locked", int'(locked), 1);
      end

      // Randomized pulse trains, en drops, long lows and resets.
      for (int it = 0; it < 250; it++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            rst = 1'b0;
         end else if (r < 5) begin
            en = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            en = 1'b1;
         end else if (r < 7) begin
            drive(1'b0, $urandom_range(200, 300));
         end else begin
            square($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 4));
         end
      end

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
